ani_frame_sequencer: RTL and testbench
======================================

Name: ani_frame_sequencer

Overview:
Frame stepper for the 7-segment animation engine. It sits directly downstream of the animation-to-frame-limit lookup (`changing`). It drives the current animation index into that lookup and consumes the returned frame limit. It generates the frame counter that addresses the segment-pattern ROM, with speed control, pause/single-step, manual selection and auto-cycling through all animations.

Parameters:
- PRESCALE_BASE, 1_000_000, clock cycles per frame at speed 0; period = PRESCALE_BASE << speed.
- CNT_W, 28, prescaler counter width; must hold (PRESCALE_BASE << 7) - 1.
- NUM_ANI, 51, number of implemented animations; valid indices 0..NUM_ANI-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state, and pulse outputs are 0.
- ani_sel  in  6  manual animation request.
- auto_mode  in  1  1 = advance animation automatically at each sequence wrap; ani_sel ignored.
- pause  in  1  level; 1 holds the frame counter.
- step  in  1  single-cycle pulse; advances one frame while paused.
- speed  in  3  prescaler shift, 0 fastest, 7 slowest.
- limit  in  6  frame count for the current animation, from the lookup (combinational in `animation`).
- animation  out  6  current animation index (to the lookup and the pattern ROM).
- frame  out  6  current frame, 0..limit_q-1.
- frame_tick  out  1  one-cycle pulse on every frame advance, including wraps.
- seq_wrap  out  1  one-cycle pulse when frame wraps to 0.

Behaviour:
- Reset (async assert, sync release): animation=0, frame=0, frame_tick=0, seq_wrap=0, prescaler=0, limit_q=1, state=LOAD.
- All outputs are registered.
- States:
  - LOAD: one cycle.
    - Latch limit_q = (limit==0) ? 1 : limit.
    - Clear frame and prescaler.
    - Next state = PAUSED if pause, else RUN.
    - No ticks are generated in LOAD.
  - RUN: prescaler increments each cycle; at (PRESCALE_BASE<<speed)-1 it clears and a tick fires.
    - On tick with frame==limit_q-1: frame<=0, seq_wrap=1, frame_tick=1.
      - If auto_mode: animation <= (animation==NUM_ANI-1) ? 0 : animation+1, go to LOAD.
    - On tick otherwise: frame<=frame+1, frame_tick=1.
    - pause=1 goes to PAUSED; prescaler holds its value.
    - step is ignored.
  - PAUSED: prescaler holds.
    - step=1 acts exactly as a tick (same wrap, auto-advance and pulse rules).
    - pause=0 goes to RUN; the prescaler resumes from its held value.
- Manual change (auto_mode=0, state RUN or PAUSED):
  - Condition: clamp(ani_sel) != animation, where clamp = ani_sel>=NUM_ANI ? NUM_ANI-1 : ani_sel.
  - Action: animation<=clamp(ani_sel), go to LOAD.
  - No frame_tick or seq_wrap is issued that cycle.
- Priority within a cycle: manual change > tick/step > pause transition.
  - A tick coinciding with pause rising is processed, then the state moves to PAUSED.
- limit sampling:
  - limit is sampled only in LOAD, one cycle after animation changes, so the lookup has settled.
  - limit changes at any other time are ignored.
- limit_q==1: frame stays 0; every tick pulses both frame_tick and seq_wrap.
- Switching auto_mode 1->0 does not change animation unless ani_sel differs (normal manual rule).
- ena=0: no state, counter or output register changes; frame_tick and seq_wrap are forced to 0.
- speed change mid-count:
  - The new period applies immediately.
  - If the prescaler is already >= the new terminal value, tick on the next cycle and clear.
- Async reset mid-operation: outputs return to reset values immediately, regardless of clk.

Decomposition:
- Package ani_pkg:
  - ANI_W=6, FRAME_W=6, NUM_ANI=51.
  - State enum {ST_LOAD, ST_RUN, ST_PAUSED}.
  - Default PRESCALE_BASE.
- Sub-module ani_tick_gen: prescaler counter with ports clk, rst_n, en, clr, speed; output tick.
  - `en` is driven by RUN && ena; `clr` is driven by LOAD.
- The lookup itself stays outside this block; the top level wires animation -> lookup -> limit.

Test Plan:
All scenarios run with PRESCALE_BASE=4, speed=0.
1. Basic wrap: reset, ani_sel=0, limit model returns 10. frame steps 0..9 with one frame_tick every 4 cycles; the 10th tick gives frame=0 plus a seq_wrap pulse.
2. Auto-cycle: auto_mode=1, limits from the real table. At the wrap, animation goes 0->1, then a LOAD cycle, then limit_q=12 and frame counts 0..11. Force animation=50: at its wrap, animation returns to 0.
3. Manual change mid-run: at frame=5, set ani_sel=2. The next cycle gives animation=2 with no tick pulse; LOAD clears frame to 0; frame then counts 0..5 and wraps.
4. Pause and step: pause at frame=3. frame holds 3 for 100 cycles. Three step pulses (limit 6 starting at frame 3) give 4, 5, then 0 with seq_wrap. Releasing pause resumes counting.
5. Boundaries:
   - ani_sel=63: animation clamps to 50.
   - limit forced to 0: frame stays 0 and seq_wrap accompanies every frame_tick.
   - ena=0 for 20 cycles: all outputs frozen, pulses 0.
6. Async reset: drop rst_n between clock edges at frame=7, animation=3. All outputs are 0 before the next edge; after release, one LOAD cycle, then ticks resume.

Source files
------------

// File: rtl/ani_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ani_pkg
//  Description : Shared widths, animation count, sequencer state encoding and
//                the manual-selection clamp helper for the frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ani_pkg;

    localparam int ANI_W             = 6;
    localparam int FRAME_W           = 6;
    localparam int NUM_ANI           = 51;
    localparam int PRESCALE_BASE_DEF = 1_000_000;
    localparam int CNT_W_DEF         = 28;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    // Out-of-range requests select the last implemented animation.
    function automatic logic [ANI_W-1:0] clamp_ani(input logic [ANI_W-1:0] sel,
                                                   input int               n);
        if (int'(sel) >= n) begin
            return ANI_W'(n - 1);
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ani_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ani_tick_gen
//  Description : Frame-rate prescaler. Counts while enabled and fires a
//                one-cycle tick every (PRESCALE_BASE << speed) cycles. A count
//                already at or beyond a freshly shortened period ticks at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module ani_tick_gen #(
    parameter int PRESCALE_BASE = 1_000_000,
    parameter int CNT_W         = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [2:0] speed,
    output logic       tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] term;

    // Terminal count for the current speed, tick decode and next count.
    always_comb begin
        term  = (CNT_W'(PRESCALE_BASE) << speed) - CNT_W'(1);
        tick  = en && !clr && (cnt_q >= term);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Prescaler register; holds whenever not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ani_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ani_frame_sequencer
//  Description : Frame stepper for the 7-segment animation engine. Drives the
//                animation index to the frame-limit lookup, latches the limit
//                one cycle later, and steps the frame counter with speed,
//                pause/single-step, manual selection and auto-cycling.
//  Revision    : 1.0 - initial release
// ============================================================================
module ani_frame_sequencer #(
    parameter int PRESCALE_BASE = ani_pkg::PRESCALE_BASE_DEF,
    parameter int CNT_W         = ani_pkg::CNT_W_DEF,
    parameter int NUM_ANI       = ani_pkg::NUM_ANI
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] ani_sel,
    input  logic       auto_mode,
    input  logic       pause,
    input  logic       step,
    input  logic [2:0] speed,
    input  logic [5:0] limit,
    output logic [5:0] animation,
    output logic [5:0] frame,
    output logic       frame_tick,
    output logic       seq_wrap
);

    import ani_pkg::*;

    state_t             state_q;
    state_t             state_d;
    logic [ANI_W-1:0]   animation_q;
    logic [ANI_W-1:0]   animation_d;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] frame_d;
    logic [FRAME_W-1:0] limit_q;
    logic [FRAME_W-1:0] limit_d;
    logic               frame_tick_q;
    logic               frame_tick_d;
    logic               seq_wrap_q;
    logic               seq_wrap_d;

    logic [ANI_W-1:0]   sel_clamped;
    logic               manual_change;
    logic               advance;
    logic               last_frame;
    logic               tick;
    logic               tick_en;
    logic               tick_clr;

    assign tick_en  = ena && (state_q == ST_RUN);
    assign tick_clr = ena && (state_q == ST_LOAD);

    ani_tick_gen #(
        .PRESCALE_BASE (PRESCALE_BASE),
        .CNT_W         (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .speed (speed),
        .tick  (tick)
    );

    // Next-state logic: manual change outranks a frame advance, which
    // outranks the pause/run transition. Pulses default low every cycle.
    always_comb begin
        state_d       = state_q;
        animation_d   = animation_q;
        frame_d       = frame_q;
        limit_d       = limit_q;
        frame_tick_d  = 1'b0;
        seq_wrap_d    = 1'b0;

        sel_clamped   = clamp_ani(ani_sel, NUM_ANI);
        manual_change = !auto_mode && (sel_clamped != animation_q);
        advance       = (state_q == ST_RUN) ? tick : step;
        last_frame    = (frame_q == limit_q - FRAME_W'(1));

        if (ena) begin
            case (state_q)
                ST_LOAD: begin
                    // The lookup has had a full cycle to settle on animation_q.
                    limit_d = (limit == '0) ? FRAME_W'(1) : limit;
                    frame_d = '0;
                    state_d = pause ? ST_PAUSED : ST_RUN;
                end
                ST_RUN, ST_PAUSED: begin
                    if (manual_change) begin
                        animation_d = sel_clamped;
                        state_d     = ST_LOAD;
                    end else begin
                        state_d = pause ? ST_PAUSED : ST_RUN;
                        if (advance) begin
                            frame_tick_d = 1'b1;
                            if (last_frame) begin
                                frame_d    = '0;
                                seq_wrap_d = 1'b1;
                                if (auto_mode) begin
                                    animation_d = (animation_q == ANI_W'(NUM_ANI - 1)) ?
                                                  '0 : animation_q + ANI_W'(1);
                                    state_d     = ST_LOAD;
                                end
                            end else begin
                                frame_d = frame_q + FRAME_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    // State and output registers; ena low leaves everything but the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            animation_q  <= '0;
            frame_q      <= '0;
            limit_q      <= FRAME_W'(1);
            frame_tick_q <= 1'b0;
            seq_wrap_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            animation_q  <= animation_d;
            frame_q      <= frame_d;
            limit_q      <= limit_d;
            frame_tick_q <= frame_tick_d;
            seq_wrap_q   <= seq_wrap_d;
        end
    end

    assign animation  = animation_q;
    assign frame      = frame_q;
    assign frame_tick = frame_tick_q;
    assign seq_wrap   = seq_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_ani_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ani_frame_sequencer
//  Description : Self-checking bench for ani_frame_sequencer with a frame-limit
//                table standing in for the external lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ani_frame_sequencer;

    localparam int PB    = 4;
    localparam int NANI  = 51;

    typedef struct packed {
        logic [5:0] anim;
        logic [5:0] frame;
        logic       tick;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [5:0] ani_sel = '0;
    logic       auto_mode = 1'b0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic [2:0] speed = '0;
    logic [5:0] limit;
    logic [5:0] animation;
    logic [5:0] frame;
    logic       frame_tick;
    logic       seq_wrap;
    logic       force_zero = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // Reference model state
    int m_anim, m_frame, m_limit, m_cnt;
    bit m_loading, m_paused, m_tick, m_wrap;

    always #5 clk = ~clk;

    // Frame-limit table standing in for the external lookup.
    function automatic int lut(input int a);
        case (a)
            0:       return 10;
            1:       return 12;
            2:       return 6;
            3:       return 9;
            4:       return 1;
            50:      return 5;
            default: return (a % 7) + 2;
        endcase
    endfunction

    assign limit = force_zero ? 6'd0 : 6'(lut(int'(animation)));

    ani_frame_sequencer #(
        .PRESCALE_BASE (PB),
        .CNT_W         (12),
        .NUM_ANI       (NANI)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ani_sel    (ani_sel),
        .auto_mode  (auto_mode),
        .pause      (pause),
        .step       (step),
        .speed      (speed),
        .limit      (limit),
        .animation  (animation),
        .frame      (frame),
        .frame_tick (frame_tick),
        .seq_wrap   (seq_wrap)
    );

    task automatic model_reset();
        m_anim = 0; m_frame = 0; m_limit = 1; m_cnt = 0;
        m_loading = 1'b1; m_paused = 1'b0; m_tick = 1'b0; m_wrap = 1'b0;
    endtask

    task automatic push_expect();
        exp_t e;
        e.anim  = 6'(m_anim);
        e.frame = 6'(m_frame);
        e.tick  = m_tick;
        e.wrap  = m_wrap;
        sb.push_back(e);
    endtask

    // One clock edge of the behavioural model: frame = elapsed ticks mod limit.
    task automatic model_step();
        int sel;
        int lv;
        bit adv;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!ena) return;
        if (m_loading) begin
            lv        = force_zero ? 0 : lut(m_anim);
            m_limit   = (lv == 0) ? 1 : lv;
            m_frame   = 0;
            m_cnt     = 0;
            m_loading = 1'b0;
            m_paused  = pause;
            return;
        end
        sel = (int'(ani_sel) >= NANI) ? NANI - 1 : int'(ani_sel);
        adv = 1'b0;
        if (!m_paused) begin
            if (m_cnt >= (PB << speed) - 1) begin
                adv   = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            adv = step;
        end
        if (!auto_mode && sel != m_anim) begin
            m_anim    = sel;
            m_loading = 1'b1;
        end else if (adv) begin
            m_tick  = 1'b1;
            m_frame = (m_frame + 1) % m_limit;
            if (m_frame == 0) begin
                m_wrap = 1'b1;
                if (auto_mode) begin
                    m_anim    = (m_anim + 1) % NANI;
                    m_loading = 1'b1;
                end
            end
        end
        if (!m_loading) m_paused = pause;
    endtask

    // Model driver: predict the post-edge outputs and queue them.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            push_expect();
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({animation, frame, frame_tick, seq_wrap} !== {e.anim, e.frame, e.tick, e.wrap}) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t: got anim=%0d frame=%0d tick=%0b wrap=%0b, expected anim=%0d frame=%0d tick=%0b wrap=%0b",
                             $time, animation, frame, frame_tick, seq_wrap, e.anim, e.frame, e.tick, e.wrap);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_for(input int a, input int f, input int budget, input string what);
        int k = 0;
        while (!(int'(animation) == a && int'(frame) == f)) begin
            @(negedge clk);
            k++;
            if (k >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_%s: timed out after %0d cycles, got anim=%0d frame=%0d, required anim=%0d frame=%0d",
                         what, k, animation, frame, a, f);
                return;
            end
        end
    endtask

    task automatic step_pulse();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        cycles(3);
    endtask

    // Drop reset between edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        model_reset();
        push_expect();
        cycles(2);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        cycles(3);
        rst_n = 1'b1;

        // Basic wrap on animation 0 (limit 10)
        cycles(60);

        // Auto-cycle 0 -> 1 -> 2, then from 50 back to 0
        auto_mode = 1'b1;
        cycles(130);
        auto_mode = 1'b0;
        ani_sel   = 6'd50;
        cycles(4);
        auto_mode = 1'b1;
        cycles(35);
        ani_sel   = 6'd0;
        auto_mode = 1'b0;
        cycles(3);

        // Manual change mid-run at frame 5
        wait_for(0, 5, 200, "frame5");
        ani_sel = 6'd2;
        cycles(60);

        // Pause at frame 3 then three steps
        wait_for(2, 3, 100, "frame3");
        pause = 1'b1;
        cycles(100);
        step_pulse();
        step_pulse();
        step_pulse();
        pause = 1'b0;
        cycles(40);

        // Boundaries: clamp, limit 1 animation, forced zero limit, ena low
        ani_sel = 6'd63;
        cycles(30);
        ani_sel = 6'd4;
        cycles(20);
        force_zero = 1'b1;
        ani_sel    = 6'd5;
        cycles(30);
        force_zero = 1'b0;
        ani_sel    = 6'd2;
        cycles(10);
        ena = 1'b0;
        cycles(20);
        ena = 1'b1;
        cycles(10);

        // Async reset at animation 3, frame 7
        ani_sel = 6'd3;
        wait_for(3, 7, 300, "frame7");
        async_reset();
        cycles(30);

        // Randomized traffic, including speed changes mid-count
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0)  ani_sel    = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 199) == 0) auto_mode  = ~auto_mode;
            if ($urandom_range(0, 39) == 0)  pause      = ~pause;
            if ($urandom_range(0, 99) == 0)  speed      = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 299) == 0) force_zero = ~force_zero;
            step = ($urandom_range(0, 7) == 0);
            ena  = ($urandom_range(0, 9) != 0);
        end
        step = 1'b0;
        ena  = 1'b1;
        cycles(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
